// File: rtl/cla_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cla_seq_controller
//  Description : Multi-cycle adder sequencer. Adds two WIDTH-bit operands
//                plus a carry-in by driving one external combinational 4-bit
//                carry-lookahead adder, one nibble per clock, LSB nibble
//                first. The carry between nibbles is chained through a
//                register.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - request, honoured only while not busy
//                A_in, B_in,
//                Cin_in          - operands, captured on accepted start
//                busy, done      - RUN indication / one-cycle result pulse
//                Sum, Cout_out   - result registers, held until next start
//                add_A, add_B,
//                add_Cin         - drive to the external 4-bit adder
//                add_S, add_Cout - result from the external 4-bit adder
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_seq_controller #(
    parameter int WIDTH = 16    // multiple of 4, at least 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout_out,
    output logic [3:0]       add_A,
    output logic [3:0]       add_B,
    output logic             add_Cin,
    input  logic [3:0]       add_S,
    input  logic             add_Cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;

    // start is only honoured when no nibble pass is in flight; the DONE
    // cycle counts as not busy so back-to-back requests are accepted.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_idx == C_LAST_IDX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand nibble selection for the current pass
    // ------------------------------------------------------------------
    always_comb begin
        w_nib_a = 4'd0;
        w_nib_b = 4'd0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_nib_a = r_a[4*n +: 4];
                w_nib_b = r_b[4*n +: 4];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic: the adder is driven only during RUN, zero otherwise
    // ------------------------------------------------------------------
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_A   = 4'd0;
        add_B   = 4'd0;
        add_Cin = 1'b0;
        case (r_state)
            S_RUN: begin
                busy    = 1'b1;
                add_A   = w_nib_a;
                add_B   = w_nib_b;
                // First pass takes the captured carry-in, later passes
                // take the carry produced by the previous nibble.
                add_Cin = (r_idx == '0) ? r_cin : r_carry;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, nibble-wise result write, carry chain
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            // Sum/Cout_out are left untouched here; they are overwritten
            // nibble by nibble as the passes complete.
            r_a   <= A_in;
            r_b   <= B_in;
            r_cin <= Cin_in;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (r_idx == IDX_W'(n)) begin
                    r_sum[4*n +: 4] <= add_S;
                end
            end
            r_carry <= add_Cout;
            if (w_last) begin
                r_cout <= add_Cout;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    assign Sum      = r_sum;
    assign Cout_out = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_seq_controller
//  Description : Self-checking bench for cla_seq_controller (WIDTH=16) with
//                a behavioural 4-bit adder attached. A reference model works
//                from the arithmetic result and a cycle phase count; a
//                compare process checks every output on each falling edge,
//                and directed tests pin literal results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_seq_controller;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             Cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout_out;
    logic [3:0]       add_A;
    logic [3:0]       add_B;
    logic             add_Cin;
    logic [3:0]       add_S;
    logic             add_Cout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_seq_controller #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A_in     (A_in),
        .B_in     (B_in),
        .Cin_in   (Cin_in),
        .busy     (busy),
        .done     (done),
        .Sum      (Sum),
        .Cout_out (Cout_out),
        .add_A    (add_A),
        .add_B    (add_B),
        .add_Cin  (add_Cin),
        .add_S    (add_S),
        .add_Cout (add_Cout)
    );

    // External 4-bit adder
    assign {add_Cout, add_S} = 5'(add_A) + 5'(add_B) + 5'(add_Cin);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase -1 = idle, 0..N-1 = pass k, N = done cycle.
    // ------------------------------------------------------------------
    int          m_phase = -1;
    bit          m_valid = 1'b0;
    longint      m_a = 0, m_b = 0, m_cin = 0, m_res = 0;
    logic [15:0] m_sum = 16'd0;
    logic        m_cout = 1'b0;

    // Carry entering nibble k, from plain arithmetic on the low 4k bits.
    function automatic logic carry_into(int k);
        longint msk;
        longint s;
        msk = (64'd1 << (4 * k)) - 1;
        s   = (m_a & msk) + (m_b & msk) + m_cin;
        return 1'((s >> (4 * k)) & 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = -1;
            m_sum   = 16'd0;
            m_cout  = 1'b0;
            m_a     = 0;
            m_b     = 0;
            m_cin   = 0;
            m_valid = 1'b1;
        end else if (!m_valid) begin
            m_phase = -1;
        end else if (start && (m_phase < 0 || m_phase == N)) begin
            m_a     = longint'(A_in);
            m_b     = longint'(B_in);
            m_cin   = longint'(Cin_in);
            m_res   = m_a + m_b + m_cin;
            m_phase = 0;
        end else if (m_phase >= 0 && m_phase < N) begin
            longint msk;
            msk   = (64'd1 << (4 * (m_phase + 1))) - 1;
            m_sum = 16'((m_res & msk) | (longint'(m_sum) & ~msk));
            if (m_phase == N - 1) m_cout = 1'((m_res >> WIDTH) & 1);
            m_phase++;
        end else if (m_phase == N) begin
            m_phase = -1;
        end
    end

    // ------------------------------------------------------------------
    // Compare process plus trace capture
    // ------------------------------------------------------------------
    logic [3:0] q_a[$];
    logic       q_cin[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            bit run;
            run = (m_phase >= 0 && m_phase < N);
            check("busy",    busy,     run);
            check("done",    done,     m_phase == N);
            check("Sum",     Sum,      m_sum);
            check("Cout",    Cout_out, m_cout);
            check("add_A",   add_A,    run ? ((m_a >> (4 * m_phase)) & 15) : 0);
            check("add_B",   add_B,    run ? ((m_b >> (4 * m_phase)) & 15) : 0);
            check("add_Cin", add_Cin,  run ? carry_into(m_phase) : 1'b0);
            if (busy) begin
                q_a.push_back(add_A);
                q_cin.push_back(add_Cin);
            end
            if (done) done_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 30);
        if (done !== 1'b1) check("done_timeout", 0, 1);
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
        q_a.delete();
        q_cin.delete();
        A_in   = a;
        B_in   = b;
        Cin_in = c;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        wait_done(lat);
    endtask

    function automatic longint seq_a();
        longint s = 0;
        foreach (q_a[i]) s = (s << 4) | longint'(q_a[i]);
        return s;
    endfunction

    function automatic longint seq_cin();
        longint s = 0;
        foreach (q_cin[i]) s = (s << 4) | longint'(q_cin[i]);
        return s;
    endfunction

    initial begin
        int lat;
        int d0;
        rst = 1'b1; start = 1'b0; A_in = '0; B_in = '0; Cin_in = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum",  Sum, 16'h0000);
        check("rst_cout", Cout_out, 0);
        check("rst_addA", add_A, 0);

        // Basic add
        d0 = done_cnt;
        launch(16'h1234, 16'h4321, 1'b0, lat);
        check("t1_latency", lat, 5);
        check("t1_sum", Sum, 16'h5555);
        check("t1_cout", Cout_out, 0);
        check("t1_addA_seq", seq_a(), 64'h4321);
        @(negedge clk);
        check("t1_done_fall", done, 0);
        check("t1_done_pulses", done_cnt - d0, 1);

        // Full carry ripple
        launch(16'hFFFF, 16'h0001, 1'b0, lat);
        check("t2_sum", Sum, 16'h0000);
        check("t2_cout", Cout_out, 1);
        check("t2_cin_seq", seq_cin(), 64'h0111);

        // Carry-in with every nibble overflowing, then hold
        launch(16'h8888, 16'h8888, 1'b1, lat);
        check("t3_sum", Sum, 16'h1111);
        check("t3_cout", Cout_out, 1);
        repeat (3) @(negedge clk);
        check("t3_hold_sum", Sum, 16'h1111);
        check("t3_hold_cout", Cout_out, 1);

        // start while busy is ignored
        d0 = done_cnt;
        A_in = 16'h0005; B_in = 16'h0007; Cin_in = 1'b0; start = 1'b1;
        cyc();
        A_in = 16'h0000; B_in = 16'h0000;
        cyc();
        cyc();
        start = 1'b0;
        wait_done(lat);
        check("t4_sum", Sum, 16'h000C);
        check("t4_cout", Cout_out, 0);
        @(negedge clk);
        check("t4_done_pulses", done_cnt - d0, 1);

        // Reset in the middle of a run (asserted during pass k=2)
        A_in = 16'h1234; B_in = 16'h1111; Cin_in = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_sum", Sum, 16'h0000);
        check("t5_cout", Cout_out, 0);
        check("t5_addA", add_A, 0);
        launch(16'h0009, 16'h0006, 1'b0, lat);
        check("t5_sum2", Sum, 16'h000F);
        check("t5_latency", lat, 5);

        // Back-to-back: start accepted in the DONE cycle
        launch(16'h0100, 16'h0200, 1'b0, lat);
        check("t6_first_sum", Sum, 16'h0300);
        A_in = 16'h000F; B_in = 16'h0001; Cin_in = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(lat);
        check("t6_latency", lat, 5);
        check("t6_sum", Sum, 16'h0010);
        check("t6_cout", Cout_out, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
